channel_row_mapper: RTL and testbench

Converts a channel number and sample value into the vertical pixel row where the trace point is drawn. This is the write-side inverse of the pixel-row-to-channel decoder. On each `update` request, the block computes the vertical layout of the enabled channels once: channel count, height per channel, and per-channel top offset. It then serves pipelined lookups from the trace renderer, so the display path never needs a combinational divider.

---
 rtl/channel_row_mapper.sv | 181 ++++++++++++++++++
 tb/tb_channel_row_mapper.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_row_mapper.sv
// Maps (channel, sample) to the pixel row of a trace point. An update computes the
// vertical channel layout sequentially; lookups are served by a 2-stage pipeline.
module channel_row_mapper #(
    parameter int MAX_CHAN_COUNT = 10,
    parameter int OFFSET         = 0,
    parameter int SAMPLE_W       = 8,
    parameter int VGA_VER_RES    = 480,
    parameter int ROW_W          = $clog2(VGA_VER_RES),
    parameter int CH_W           = $clog2(MAX_CHAN_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
    input  logic                      update,
    output logic                      busy,
    output logic                      ready,
    output logic [ROW_W-1:0]          channel_height,
    input  logic                      lookup_valid,
    input  logic [CH_W-1:0]           lookup_channel,
    input  logic [SAMPLE_W-1:0]       lookup_sample,
    output logic                      out_valid,
    output logic                      out_visible,
    output logic [ROW_W-1:0]          out_row,
    output logic [ROW_W-1:0]          out_offset
);

    localparam int CNT_W  = $clog2(MAX_CHAN_COUNT + 1);
    localparam int DIV_W  = $clog2(ROW_W);
    localparam int PROD_W = SAMPLE_W + ROW_W;
    localparam logic [ROW_W-1:0] DIVIDEND = ROW_W'(VGA_VER_RES - OFFSET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DIVIDE,
        S_OFFSETS
    } state_t;

    state_t                    state_q, state_d;
    logic [MAX_CHAN_COUNT-1:0] en_q;
    logic [CNT_W-1:0]          count_q, pop_count;
    logic [DIV_W-1:0]          div_cnt_q;
    logic [ROW_W-1:0]          rem_q, rem_next, quot_q, quot_next;
    logic [ROW_W:0]            rem_shift;
    logic                      rem_ge, div_last, slot_last;
    logic [CH_W-1:0]           slot_q;
    logic [ROW_W-1:0]          acc_q;
    logic [ROW_W-1:0]          offset_tbl [MAX_CHAN_COUNT];

    logic                      chan_ok;
    logic [CH_W-1:0]           lk_idx;
    logic                      v1_q, vis1_q;
    logic [ROW_W-1:0]          off1_q;
    logic [PROD_W-1:0]         prod1_q;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
            pop_count = pop_count + CNT_W'(en_q[i]);
        end
    end

    // Restoring division of a constant dividend, one quotient bit per cycle, MSB first.
    assign rem_shift = {rem_q, DIVIDEND[div_cnt_q]};
    assign rem_ge    = rem_shift >= (ROW_W + 1)'(count_q);
    assign rem_next  = ROW_W'(rem_ge ? rem_shift - (ROW_W + 1)'(count_q) : rem_shift);
    assign quot_next = ROW_W'({quot_q, rem_ge});
    assign div_last  = (div_cnt_q == '0);
    assign slot_last = (32'(slot_q) == MAX_CHAN_COUNT - 1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: next state defaults to the current state first, so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (update) state_d = S_COUNT;
            S_COUNT:   state_d = (pop_count == '0) ? S_IDLE : S_DIVIDE;
            S_DIVIDE:  if (div_last) state_d = S_OFFSETS;
            S_OFFSETS: if (slot_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q           <= '0;
            count_q        <= '0;
            div_cnt_q      <= '0;
            rem_q          <= '0;
            quot_q         <= '0;
            slot_q         <= '0;
            acc_q          <= '0;
            ready          <= 1'b0;
            channel_height <= '0;
            // NOTE: the offset table is reset because lookups may read it before any layout exists.
            for (int k = 0; k < MAX_CHAN_COUNT; k++) offset_tbl[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (update) begin
                        en_q  <= channel_enable;
                        ready <= 1'b0;
                    end
                end
                S_COUNT: begin
                    count_q   <= pop_count;
                    rem_q     <= '0;
                    quot_q    <= '0;
                    div_cnt_q <= DIV_W'(ROW_W - 1);
                    if (pop_count == '0) begin
                        channel_height <= '0;
                        ready          <= 1'b1;
                        for (int k = 0; k < MAX_CHAN_COUNT; k++) offset_tbl[k] <= '0;
                    end
                end
                S_DIVIDE: begin
                    rem_q     <= rem_next;
                    quot_q    <= quot_next;
                    div_cnt_q <= div_cnt_q - DIV_W'(1);
                    if (div_last) begin
                        channel_height <= quot_next;
                        acc_q          <= ROW_W'(OFFSET);
                        slot_q         <= '0;
                    end
                end
                S_OFFSETS: begin
                    if (en_q[slot_q]) begin
                        offset_tbl[slot_q] <= acc_q;
                        acc_q              <= acc_q + channel_height;
                    end else begin
                        offset_tbl[slot_q] <= '0;
                    end
                    slot_q <= slot_q + CH_W'(1);
                    if (slot_last) ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Out-of-range channels are steered to slot 0 for the table read and masked by chan_ok.
    assign chan_ok = 32'(lookup_channel) < MAX_CHAN_COUNT;
    assign lk_idx  = chan_ok ? lookup_channel : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            vis1_q      <= 1'b0;
            off1_q      <= '0;
            prod1_q     <= '0;
            out_valid   <= 1'b0;
            out_visible <= 1'b0;
            out_row     <= '0;
            out_offset  <= '0;
        end else begin
            v1_q    <= lookup_valid;
            vis1_q  <= lookup_valid && ready && chan_ok && en_q[lk_idx];
            off1_q  <= offset_tbl[lk_idx];
            prod1_q <= PROD_W'(lookup_sample) * PROD_W'(channel_height);

            out_valid <= v1_q;
            if (vis1_q) begin
                out_visible <= 1'b1;
                out_offset  <= off1_q;
                out_row     <= off1_q + channel_height - ROW_W'(1) - ROW_W'(prod1_q >> SAMPLE_W);
            end else begin
                out_visible <= 1'b0;
                out_offset  <= '0;
                out_row     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_channel_row_mapper.sv
// Self-checking bench for channel_row_mapper: directed layout cases with literal
// expectations plus randomized traffic compared every cycle against a layout model.
module tb_channel_row_mapper;

    localparam int MAXC = 10;
    localparam int SW   = 8;
    localparam int RW   = 9;
    localparam int CW   = 4;
    localparam int RES  = 480;
    localparam int OFS  = 0;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [MAXC-1:0] channel_enable = '0;
    logic            update = 1'b0;
    logic            busy, ready;
    logic [RW-1:0]   channel_height;
    logic            lookup_valid = 1'b0;
    logic [CW-1:0]   lookup_channel = '0;
    logic [SW-1:0]   lookup_sample = '0;
    logic            out_valid, out_visible;
    logic [RW-1:0]   out_row, out_offset;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    channel_row_mapper dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .channel_enable (channel_enable),
        .update         (update),
        .busy           (busy),
        .ready          (ready),
        .channel_height (channel_height),
        .lookup_valid   (lookup_valid),
        .lookup_channel (lookup_channel),
        .lookup_sample  (lookup_sample),
        .out_valid      (out_valid),
        .out_visible    (out_visible),
        .out_row        (out_row),
        .out_offset     (out_offset)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          valid;
        logic          visible;
        logic [RW-1:0] row;
        logic [RW-1:0] off;
    } exp_t;

    exp_t            s1 = '0, s2 = '0;
    bit              m_busy = 0, m_ready = 0;
    int              m_pending = 0;
    logic [MAXC-1:0] m_mask = '0;
    int              m_h = 0;
    int              m_off [MAXC];

    function automatic void compute_layout();
        int n, acc;
        n   = $countones(m_mask);
        m_h = (n == 0) ? 0 : (RES - OFS) / n;
        acc = OFS;
        for (int k = 0; k < MAXC; k++) begin
            if (m_mask[k]) begin
                m_off[k] = acc;
                acc += m_h;
            end else begin
                m_off[k] = 0;
            end
        end
    endfunction

    function automatic exp_t predict(input logic v, input logic [CW-1:0] ch, input logic [SW-1:0] s);
        exp_t e;
        int   c;
        e       = '0;
        e.valid = v;
        c       = int'(ch);
        if (v && m_ready && c < MAXC) begin
            if (m_mask[c]) begin
                e.visible = 1'b1;
                e.off     = RW'(m_off[c]);
                e.row     = RW'(m_off[c] + m_h - 1 - (int'(s) * m_h) / 256);
            end
        end
        return e;
    endfunction

    initial begin
        for (int k = 0; k < MAXC; k++) m_off[k] = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                s1 = '0; s2 = '0;
                m_busy = 0; m_ready = 0; m_pending = 0; m_mask = '0; m_h = 0;
            end else begin
                s2 = s1;
                s1 = predict(lookup_valid, lookup_channel, lookup_sample);
                if (m_busy) begin
                    m_pending--;
                    if (m_pending == 0) begin
                        m_busy  = 0;
                        m_ready = 1;
                        compute_layout();
                    end
                end else if (update) begin
                    m_mask    = channel_enable;
                    m_ready   = 0;
                    m_busy    = 1;
                    m_pending = (channel_enable == '0) ? 1 : 1 + RW + MAXC;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("cmp_out_valid", out_valid, s2.valid);
                if (s2.valid) begin
                    check("cmp_out_visible", out_visible, s2.visible);
                    check("cmp_out_row", out_row, s2.row);
                    check("cmp_out_offset", out_offset, s2.off);
                end
                check("cmp_busy", busy, m_busy);
                check("cmp_ready", ready, m_ready);
                if (m_ready) check("cmp_channel_height", channel_height, m_h);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed helpers ----------------
    task automatic do_update(input logic [MAXC-1:0] mask);
        @(negedge clk);
        channel_enable = mask;
        update         = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, exp_lat);
    endtask

    task automatic lookup_expect(input string name, input int ch, input int s,
                                 input int vis, input int row, input int off);
        @(negedge clk);
        lookup_valid   = 1'b1;
        lookup_channel = CW'(ch);
        lookup_sample  = SW'(s);
        @(negedge clk);
        lookup_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_visible"}, out_visible, vis);
        check({name, "_row"}, out_row, row);
        check({name, "_offset"}, out_offset, off);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_ready"}, ready, 0);
        check({name, "_height"}, channel_height, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_visible"}, out_visible, 0);
        check({name, "_out_row"}, out_row, 0);
        check({name, "_out_offset"}, out_offset, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 reset_n = 1'b1;

        // Basic three-channel layout.
        do_update(10'b0000100101);
        wait_ready("basic_latency", 20);
        check("basic_height", channel_height, 160);
        lookup_expect("b_ch0_s0", 0, 0, 1, 159, 0);
        lookup_expect("b_ch2_s0", 2, 0, 1, 319, 160);
        lookup_expect("b_ch2_s255", 2, 255, 1, 160, 160);
        lookup_expect("b_ch2_s128", 2, 128, 1, 239, 160);
        lookup_expect("b_ch5_s0", 5, 0, 1, 479, 320);
        lookup_expect("b_ch1", 1, 77, 0, 0, 0);
        lookup_expect("b_ch12", 12, 0, 0, 0, 0);

        // Update coincident with a lookup: the lookup sees the old layout.
        @(negedge clk);
        channel_enable = '1;
        update         = 1'b1;
        lookup_valid   = 1'b1;
        lookup_channel = CW'(2);
        lookup_sample  = '0;
        @(negedge clk);
        update       = 1'b0;
        lookup_valid = 1'b0;
        @(negedge clk);
        check("coinc_visible", out_visible, 1);
        check("coinc_row", out_row, 319);
        check("coinc_offset", out_offset, 160);
        wait_ready("full_latency", 19);
        check("full_height", channel_height, 48);
        lookup_expect("f_ch9_s0", 9, 0, 1, 479, 432);

        // Uneven split.
        do_update(10'b0001111111);
        wait_ready("uneven_latency", 20);
        check("uneven_height", channel_height, 68);
        lookup_expect("u_ch6_s255", 6, 255, 1, 408, 408);

        // Update while busy is ignored.
        do_update(10'b0000000011);
        repeat (4) @(negedge clk);
        channel_enable = '1;
        update         = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_ready("busy_ignore_latency", 15);
        check("busy_ignore_height", channel_height, 240);
        lookup_expect("bi_ch1_s0", 1, 0, 1, 479, 240);
        lookup_expect("bi_ch9", 9, 0, 0, 0, 0);

        // No channels enabled.
        do_update('0);
        wait_ready("zero_latency", 1);
        check("zero_height", channel_height, 0);
        lookup_expect("z_ch0", 0, 10, 0, 0, 0);
        lookup_expect("z_ch5", 5, 200, 0, 0, 0);

        // Reset in the middle of the division.
        do_update(10'b0000100101);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ready", ready, 0);
        do_update(10'b1000000001);
        wait_ready("post_reset_latency", 20);
        check("post_reset_height", channel_height, 240);
        lookup_expect("pr_ch9_s0", 9, 0, 1, 479, 240);

        // Back-to-back lookups, one per cycle.
        do_update(10'b0000100101);
        wait_ready("b2b_layout_latency", 20);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 16) begin
                lookup_valid   = 1'b1;
                lookup_channel = CW'(2);
                lookup_sample  = SW'(i);
            end else begin
                lookup_valid = 1'b0;
            end
            if (i >= 2) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_row", out_row, 319 - ((i - 2) * 160) / 256);
            end
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            lookup_valid   = ($urandom_range(0, 3) != 0);
            lookup_channel = CW'($urandom_range(0, 15));
            lookup_sample  = SW'($urandom);
            update         = ($urandom_range(0, 29) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0)      channel_enable = '0;
            else if (r == 1) channel_enable = '1;
            else             channel_enable = MAXC'($urandom);
        end
        @(negedge clk);
        update       = 1'b0;
        lookup_valid = 1'b0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
